// File: rtl/spi_neopixel_pkg.sv
// Shared types and sizing helpers for the spi-neopixel pipeline.
package spi_neopixel_pkg;

    typedef enum logic [1:0] {
        L_IDLE,
        L_ACK,
        L_RUN
    } launch_state_t;

    localparam int ACK_TIMEOUT = 4;

    function automatic int frame_bytes(input int leds);
        return leds * 3;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI slave byte receiver, oversampled in the system clock domain.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_sck,
    input  logic       i_spi_cs_n,
    input  logic       i_spi_mosi,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_cs_fall,
    output logic       o_cs_rise
);

    // One flop beyond the synchroniser keeps the previous level for edge detect.
    logic [SYNC_STAGES:0]   sck_sr;
    logic [SYNC_STAGES:0]   cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;

    logic sck_s, cs_s, mosi_s, sck_rise;

    assign sck_s     = sck_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_sr[SYNC_STAGES];
    assign o_cs_fall = ~cs_s & cs_sr[SYNC_STAGES];
    assign o_cs_rise = cs_s & ~cs_sr[SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sr       <= '0;
            cs_sr        <= '1;
            mosi_sr      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
        end else begin
            sck_sr       <= {sck_sr[SYNC_STAGES-1:0], i_spi_sck};
            cs_sr        <= {cs_sr[SYNC_STAGES-1:0], i_spi_cs_n};
            mosi_sr      <= {mosi_sr[SYNC_STAGES-2:0], i_spi_mosi};
            o_byte_valid <= 1'b0;
            if (o_cs_fall || o_cs_rise) begin
                bit_cnt <= '0;
            end else if (!cs_s && sck_rise) begin
                shreg   <= {shreg[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    o_byte_valid <= 1'b1;
                    o_byte       <= {shreg, mosi_s};
                end
            end
        end
    end

endmodule

// File: rtl/spi_frame_buffer.sv
// Ping-pong frame buffer fed by SPI; commits whole frames and launches the driver.
module spi_frame_buffer
    import spi_neopixel_pkg::*;
#(
    parameter  int LEDS        = 200,
    parameter  int SYNC_STAGES = 2,
    localparam int FRAME_BYTES = frame_bytes(LEDS),
    localparam int AW          = $clog2(FRAME_BYTES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_spi_sck,
    input  logic          i_spi_cs_n,
    input  logic          i_spi_mosi,
    output logic          o_start,
    input  logic          i_busy,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data,
    output logic          o_frame_ok,
    output logic          o_frame_err
);

    localparam int            CW       = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] FULL     = CW'(FRAME_BYTES);
    localparam logic [2:0]    ACK_LAST = 3'(ACK_TIMEOUT - 1);

    logic       rx_valid, cs_fall, cs_rise;
    logic [7:0] rx_byte;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_spi_sck   (i_spi_sck),
        .i_spi_cs_n  (i_spi_cs_n),
        .i_spi_mosi  (i_spi_mosi),
        .o_byte_valid(rx_valid),
        .o_byte      (rx_byte),
        .o_cs_fall   (cs_fall),
        .o_cs_rise   (cs_rise)
    );

    logic [7:0]    mem [2][FRAME_BYTES];
    logic          disp_sel, pending, err;
    logic [CW-1:0] byte_cnt;
    logic          wr_ok, commit, accept, launch_go;
    launch_state_t lstate, lstate_n;
    logic [2:0]    ack_cnt;

    // A pending frame owns the write half until it is launched.
    assign wr_ok  = !pending && (byte_cnt != FULL);
    // err implies bytes arrived, so an overrun-only frame still reports.
    assign commit = cs_rise && ((byte_cnt != '0) || err);
    assign accept = (byte_cnt == FULL) && !err && !pending;

    always_ff @(posedge i_clk) begin
        if (rx_valid && wr_ok) mem[~disp_sel][byte_cnt[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt    <= '0;
            err         <= 1'b0;
            pending     <= 1'b0;
            disp_sel    <= 1'b0;
            o_start     <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_start     <= launch_go;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            if (cs_fall) begin
                byte_cnt <= '0;
                err      <= 1'b0;
            end else if (rx_valid) begin
                if (wr_ok) byte_cnt <= byte_cnt + 1'b1;
                else       err      <= 1'b1;
            end
            if (launch_go) begin
                pending  <= 1'b0;
                disp_sel <= ~disp_sel;
            end
            if (commit) begin
                if (accept) begin
                    o_frame_ok <= 1'b1;
                    pending    <= 1'b1;
                end else begin
                    o_frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lstate  <= L_IDLE;
            ack_cnt <= '0;
        end else begin
            lstate  <= lstate_n;
            ack_cnt <= (lstate == L_ACK) ? ack_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        lstate_n  = lstate;
        launch_go = 1'b0;
        case (lstate)
            L_IDLE: if (pending && !i_busy) begin
                launch_go = 1'b1;
                lstate_n  = L_ACK;
            end
            L_ACK: begin
                if (i_busy)                   lstate_n = L_RUN;
                else if (ack_cnt == ACK_LAST) lstate_n = L_IDLE;
            end
            L_RUN:   if (!i_busy) lstate_n = L_IDLE;
            default: lstate_n = L_IDLE;
        endcase
    end

    always_comb begin
        o_rd_data = 8'h00;
        if (CW'(i_rd_addr) < FULL) o_rd_data = mem[disp_sel][i_rd_addr];
    end

endmodule

// File: tb/tb_spi_frame_buffer.sv
// Directed bench for spi_frame_buffer using a short frame (8 LEDs, 24 bytes).
module tb_spi_frame_buffer;
    import spi_neopixel_pkg::*;

    localparam int LEDS = 8;
    localparam int FB   = LEDS * 3;
    localparam int AW   = $clog2(FB);

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_spi_sck = 1'b0;
    logic          i_spi_cs_n = 1'b1;
    logic          i_spi_mosi = 1'b0;
    logic          i_busy = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_start, o_frame_ok, o_frame_err;
    logic [7:0]    o_rd_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0, n_ok = 0, n_err = 0, n_start = 0, ok_cyc = 0, start_cyc = 0;

    spi_frame_buffer #(.LEDS(LEDS), .SYNC_STAGES(2)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_spi_sck  (i_spi_sck),
        .i_spi_cs_n (i_spi_cs_n),
        .i_spi_mosi (i_spi_mosi),
        .o_start    (o_start),
        .i_busy     (i_busy),
        .i_rd_addr  (i_rd_addr),
        .o_rd_data  (o_rd_data),
        .o_frame_ok (o_frame_ok),
        .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_frame_ok)  begin n_ok <= n_ok + 1; ok_cyc <= cyc; end
        if (o_frame_err) n_err <= n_err + 1;
        if (o_start)     begin n_start <= n_start + 1; start_cyc <= cyc; end
    end

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            i_spi_mosi = b[7-i];
            repeat (4) @(negedge i_clk);
            i_spi_sck = 1'b1;
            repeat (4) @(negedge i_clk);
            i_spi_sck = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n, input logic [7:0] off);
        i_spi_cs_n = 1'b0;
        repeat (8) @(negedge i_clk);
        for (int i = 0; i < n; i++) spi_bits(8'(off + i), 8);
        repeat (8) @(negedge i_clk);
        i_spi_cs_n = 1'b1;
    endtask

    task automatic wait_start(input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge i_clk);
            if (o_start) got = 1'b1;
        end
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [7:0] exp, input string nm);
        i_rd_addr = a;
        #1;
        tests++;
        if (o_rd_data !== exp) begin
            fails++;
            $display("FAIL %s: rd_data[%0d] got %h want %h", nm, a, o_rd_data, exp);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (4) @(negedge i_clk);
        tests += 3;
        if (o_start !== 1'b0)     begin fails++; $display("FAIL reset_start: got %b want 0", o_start); end
        if (o_frame_ok !== 1'b0)  begin fails++; $display("FAIL reset_ok: got %b want 0", o_frame_ok); end
        if (o_frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_frame_err); end
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic test_good_frame();
        int ok0, err0, st0;
        ok0 = n_ok; err0 = n_err; st0 = n_start;
        spi_frame(FB, 8'h00);
        repeat (16) @(negedge i_clk);
        tests += 4;
        if (n_ok - ok0 !== 1)   begin fails++; $display("FAIL good_ok: got %0d want 1", n_ok - ok0); end
        if (n_err - err0 !== 0) begin fails++; $display("FAIL good_err: got %0d want 0", n_err - err0); end
        if (n_start - st0 !== 1) begin fails++; $display("FAIL good_start: got %0d want 1", n_start - st0); end
        if (start_cyc - ok_cyc !== 1) begin
            fails++; $display("FAIL good_latency: got %0d want 1", start_cyc - ok_cyc);
        end
        rd_check(5'd0,  8'h00, "good_a0");
        rd_check(5'd5,  8'h05, "good_a5");
        rd_check(5'd23, 8'h17, "good_a23");
        rd_check(5'd24, 8'h00, "good_oob24");
        rd_check(5'd31, 8'h00, "good_oob31");
    endtask

    task automatic test_short_frame();
        int ok0, err0, st0;
        ok0 = n_ok; err0 = n_err; st0 = n_start;
        spi_frame(FB - 1, 8'h40);
        repeat (16) @(negedge i_clk);
        tests += 3;
        if (n_err - err0 !== 1)  begin fails++; $display("FAIL short_err: got %0d want 1", n_err - err0); end
        if (n_ok - ok0 !== 0)    begin fails++; $display("FAIL short_ok: got %0d want 0", n_ok - ok0); end
        if (n_start - st0 !== 0) begin fails++; $display("FAIL short_start: got %0d want 0", n_start - st0); end
        rd_check(5'd5, 8'h05, "short_a5");
    endtask

    task automatic test_long_frame();
        int ok0, err0, st0;
        logic [7:0] w0;
        ok0 = n_ok; err0 = n_err; st0 = n_start;
        spi_frame(FB + 1, 8'h80);
        repeat (16) @(negedge i_clk);
        tests += 4;
        if (n_err - err0 !== 1)  begin fails++; $display("FAIL long_err: got %0d want 1", n_err - err0); end
        if (n_ok - ok0 !== 0)    begin fails++; $display("FAIL long_ok: got %0d want 0", n_ok - ok0); end
        if (n_start - st0 !== 0) begin fails++; $display("FAIL long_start: got %0d want 0", n_start - st0); end
        // display half is buffer 1 here, so the write half is buffer 0
        w0 = dut.mem[0][0];
        if (w0 !== 8'h80) begin fails++; $display("FAIL long_wbuf0: got %h want 80", w0); end
        rd_check(5'd5, 8'h05, "long_a5");
    endtask

    task automatic test_busy_pending();
        int ok0, err0, st0;
        bit got;
        i_busy = 1'b1;
        ok0 = n_ok; err0 = n_err; st0 = n_start;
        spi_frame(FB, 8'h20);
        repeat (16) @(negedge i_clk);
        tests += 2;
        if (n_ok - ok0 !== 1)    begin fails++; $display("FAIL busy_ok: got %0d want 1", n_ok - ok0); end
        if (n_start - st0 !== 0) begin fails++; $display("FAIL busy_nostart: got %0d want 0", n_start - st0); end
        spi_frame(FB, 8'h60);
        repeat (16) @(negedge i_clk);
        tests += 2;
        if (n_err - err0 !== 1) begin fails++; $display("FAIL overrun_err: got %0d want 1", n_err - err0); end
        if (n_ok - ok0 !== 1)   begin fails++; $display("FAIL overrun_ok: got %0d want 1", n_ok - ok0); end
        rd_check(5'd5, 8'h05, "busy_a5_old");
        i_busy = 1'b0;
        wait_start(20, got);
        tests++;
        if (!got) begin fails++; $display("FAIL busy_start: got none want pulse within 20 cycles"); end
        i_busy = 1'b1;
        repeat (6) @(negedge i_clk);
        i_busy = 1'b0;
        repeat (4) @(negedge i_clk);
        rd_check(5'd5, 8'h25, "busy_a5_new");
        rd_check(5'd23, 8'h37, "busy_a23_new");
    endtask

    task automatic test_ack_timeout();
        int st0;
        bit got;
        launch_state_t s;
        st0 = n_start;
        spi_frame(FB, 8'h30);
        wait_start(20, got);
        tests++;
        if (!got) begin fails++; $display("FAIL tmo_start1: got none want pulse"); end
        repeat (3) @(negedge i_clk);
        s = dut.lstate;
        tests++;
        if (s !== L_ACK) begin fails++; $display("FAIL tmo_ack3: got %0d want %0d", s, L_ACK); end
        @(negedge i_clk);
        s = dut.lstate;
        tests++;
        if (s !== L_IDLE) begin fails++; $display("FAIL tmo_idle4: got %0d want %0d", s, L_IDLE); end
        rd_check(5'd5, 8'h35, "tmo_a5_first");
        spi_frame(FB, 8'h50);
        repeat (16) @(negedge i_clk);
        tests++;
        if (n_start - st0 !== 2) begin fails++; $display("FAIL tmo_start2: got %0d want 2", n_start - st0); end
        rd_check(5'd5, 8'h55, "tmo_a5_second");
    endtask

    task automatic test_reset_mid();
        int ok0, err0, st0;
        bit got;
        launch_state_t s;
        ok0 = n_ok; err0 = n_err;
        i_spi_cs_n = 1'b0;
        repeat (8) @(negedge i_clk);
        for (int i = 0; i < 10; i++) spi_bits(8'(i), 8);
        spi_bits(8'hA5, 3);
        i_rst = 1'b1;
        @(negedge i_clk);
        tests += 3;
        if (o_start !== 1'b0)     begin fails++; $display("FAIL rstbyte_start: got %b want 0", o_start); end
        if (o_frame_ok !== 1'b0)  begin fails++; $display("FAIL rstbyte_ok: got %b want 0", o_frame_ok); end
        if (o_frame_err !== 1'b0) begin fails++; $display("FAIL rstbyte_err: got %b want 0", o_frame_err); end
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        i_spi_cs_n = 1'b1;
        repeat (16) @(negedge i_clk);
        tests += 2;
        if (n_ok - ok0 !== 0)   begin fails++; $display("FAIL rstbyte_nook: got %0d want 0", n_ok - ok0); end
        if (n_err - err0 !== 0) begin fails++; $display("FAIL rstbyte_noerr: got %0d want 0", n_err - err0); end

        spi_frame(FB, 8'h10);
        wait_start(20, got);
        i_busy = 1'b1;
        repeat (3) @(negedge i_clk);
        s = dut.lstate;
        tests++;
        if (s !== L_RUN) begin fails++; $display("FAIL rstrun_pre: got %0d want %0d", s, L_RUN); end
        i_rst = 1'b1;
        @(negedge i_clk);
        s = dut.lstate;
        tests += 4;
        if (o_start !== 1'b0)     begin fails++; $display("FAIL rstrun_start: got %b want 0", o_start); end
        if (o_frame_ok !== 1'b0)  begin fails++; $display("FAIL rstrun_ok: got %b want 0", o_frame_ok); end
        if (o_frame_err !== 1'b0) begin fails++; $display("FAIL rstrun_err: got %b want 0", o_frame_err); end
        if (s !== L_IDLE)         begin fails++; $display("FAIL rstrun_state: got %0d want %0d", s, L_IDLE); end
        i_busy = 1'b0;
        i_rst  = 1'b0;
        repeat (4) @(negedge i_clk);
        ok0 = n_ok; st0 = n_start;
        spi_frame(FB, 8'h70);
        repeat (16) @(negedge i_clk);
        tests += 2;
        if (n_ok - ok0 !== 1)    begin fails++; $display("FAIL rstafter_ok: got %0d want 1", n_ok - ok0); end
        if (n_start - st0 !== 1) begin fails++; $display("FAIL rstafter_start: got %0d want 1", n_start - st0); end
        rd_check(5'd5, 8'h75, "rstafter_a5");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_long_frame();
        test_busy_pending();
        test_ack_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
